// File: rtl/fir_regfile_reader.sv
//------------------------------------------------------------------------------
// fir_regfile_reader
//
// Read-side sequencer for the FIR coefficient/sample register file. A start
// command launches a burst of reads on the regfile's registered read port.
// The module absorbs the one-cycle read latency and forwards the returned
// words, unmodified, as a valid/ready stream to the FIR MAC datapath.
// Addresses walk either up or down and wrap circularly at DEPTH, so the
// sample history can be read newest-to-oldest.
//
// Ports:
//   clk2       in   clock, all logic on the rising edge
//   rst        in   synchronous reset, active high
//   start      in   burst request pulse, only looked at while idle
//   base_addr  in   first address of the burst
//   count      in   words to read (0 legal, clipped to DEPTH)
//   dir        in   0 = ascending, 1 = descending addresses
//   busy       out  burst in progress
//   done       out  one-cycle pulse at burst completion
//   rf_ren     out  regfile read enable (registered)
//   rf_raddr   out  regfile read address (registered)
//   rf_dout    in   regfile read data, valid one cycle after rf_ren
//   m_valid    out  output stream valid
//   m_ready    in   output stream ready
//   m_data     out  output word
//   m_last     out  final word of the burst
//------------------------------------------------------------------------------
module fir_regfile_reader #(
    parameter int DEPTH     = 64,
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 6,
    parameter int CNT_W     = 7,
    parameter int BUF_DEPTH = 4
) (
    input  logic                     clk2,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         count,
    input  logic                     dir,
    output logic                     busy,
    output logic                     done,
    output logic                     rf_ren,
    output logic [ADDR_W-1:0]        rf_raddr,
    input  logic signed [WIDTH-1:0]  rf_dout,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [WIDTH-1:0]  m_data,
    output logic                     m_last
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;

    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(BUF_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    // Control state
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fin_q, fin_d;        // last word handed off; done follows
    // Read pipeline: issue -> regfile -> capture
    logic              rf_ren_q, rf_ren_d;
    logic [ADDR_W-1:0] rf_raddr_q, rf_raddr_d;
    logic              ren_last_q, ren_last_d;
    logic              cap_vld_q, cap_vld_d;
    logic              cap_last_q, cap_last_d;
    // Output buffer
    logic signed [WIDTH-1:0] buf_data_q [BUF_DEPTH];
    logic signed [WIDTH-1:0] buf_data_d [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]    buf_last_q, buf_last_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;

    logic [CNT_W-1:0] eff_cnt;
    logic [1:0]       outstanding;
    logic [SUM_W-1:0] fill;
    logic             room;
    logic             push;
    logic             pop;
    logic             head_last;

    // Explicit compares keep the wrap correct for non-power-of-2 DEPTH.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic            down);
        if (down) return (a == '0) ? ADDR_MAX : a - ADDR_W'(1);
        else      return (a == ADDR_MAX) ? '0 : a + ADDR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    assign eff_cnt     = (count > DEPTH_C) ? DEPTH_C : count;
    // Reads in flight: one at the regfile, one waiting to be captured.
    assign outstanding = {1'b0, rf_ren_q} + {1'b0, cap_vld_q};
    // Reserving buffer space for in-flight reads is what rules out overflow.
    assign fill        = SUM_W'(occ_q) + SUM_W'(outstanding);
    assign room        = fill < SUM_W'(BUF_DEPTH);
    assign push        = cap_vld_q;
    assign pop         = m_valid && m_ready;
    assign head_last   = buf_last_q[rd_ptr_q];

    always_comb begin
        // NOTE: every _d is given its hold value first, so no path through
        // this block leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        addr_d      = addr_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = fin_q;
        fin_d       = 1'b0;
        rf_ren_d    = 1'b0;
        rf_raddr_d  = rf_raddr_q;
        ren_last_d  = 1'b0;
        cap_vld_d   = rf_ren_q;
        cap_last_d  = ren_last_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;

        if (fin_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // fin_q blocks a new burst in the single cycle between the
                // last handshake and the done pulse.
                if (start && !fin_q) begin
                    if (eff_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // The buffer is empty here, so the first read goes
                        // out immediately.
                        rf_ren_d    = 1'b1;
                        rf_raddr_d  = base_addr;
                        ren_last_d  = (eff_cnt == CNT_W'(1));
                        addr_d      = next_addr(base_addr, dir);
                        dir_d       = dir;
                        remaining_d = eff_cnt - CNT_W'(1);
                        busy_d      = 1'b1;
                        state_d     = (eff_cnt == CNT_W'(1)) ? S_DRAIN : S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end else if (room) begin
                    rf_ren_d    = 1'b1;
                    rf_raddr_d  = addr_q;
                    ren_last_d  = (remaining_q == CNT_W'(1));
                    addr_d      = next_addr(addr_q, dir_q);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head_last) begin
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Data returned by the regfile lands in the buffer in issue order.
        if (push) begin
            buf_data_d[wr_ptr_q] = rf_dout;
            buf_last_d[wr_ptr_q] = cap_last_q;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fin_q       <= 1'b0;
            rf_ren_q    <= 1'b0;
            rf_raddr_q  <= '0;
            ren_last_q  <= 1'b0;
            cap_vld_q   <= 1'b0;
            cap_last_q  <= 1'b0;
            // NOTE: the buffer is only a few words, so it is cleared on reset;
            // this is what makes m_data read 0 straight after reset.
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fin_q       <= fin_d;
            rf_ren_q    <= rf_ren_d;
            rf_raddr_q  <= rf_raddr_d;
            ren_last_q  <= ren_last_d;
            cap_vld_q   <= cap_vld_d;
            cap_last_q  <= cap_last_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rf_ren   = rf_ren_q;
    assign rf_raddr = rf_raddr_q;
    assign m_valid  = (occ_q != '0);
    assign m_data   = buf_data_q[rd_ptr_q];
    // Gated so a stale flag in an empty slot never shows.
    assign m_last   = m_valid && head_last;

endmodule

// File: tb/tb_fir_regfile_reader.sv
//------------------------------------------------------------------------------
// tb_fir_regfile_reader
//
// Directed bench for fir_regfile_reader. A behavioural regfile with a
// registered read port is preloaded with mem[i] = i*3. A negedge monitor logs
// read addresses, handshakes, valid cycles and done pulses; each test then
// compares those logs with hand-derived expectations.
//------------------------------------------------------------------------------
module tb_fir_regfile_reader;

    localparam int DEPTH     = 64;
    localparam int WIDTH     = 16;
    localparam int ADDR_W    = 6;
    localparam int CNT_W     = 7;
    localparam int BUF_DEPTH = 4;

    logic                    clk2 = 1'b0;
    logic                    rst;
    logic                    start;
    logic [ADDR_W-1:0]       base_addr;
    logic [CNT_W-1:0]        count;
    logic                    dir;
    logic                    busy;
    logic                    done;
    logic                    rf_ren;
    logic [ADDR_W-1:0]       rf_raddr;
    logic signed [WIDTH-1:0] rf_dout;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [WIDTH-1:0] m_data;
    logic                    m_last;

    always #5 clk2 = ~clk2;

    fir_regfile_reader #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .CNT_W    (CNT_W),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk2     (clk2),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .count    (count),
        .dir      (dir),
        .busy     (busy),
        .done     (done),
        .rf_ren   (rf_ren),
        .rf_raddr (rf_raddr),
        .rf_dout  (rf_dout),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    // Register file model with a registered read port.
    logic [WIDTH-1:0] rf_mem [DEPTH];
    always @(posedge clk2) begin
        if (rf_ren) rf_dout <= rf_mem[rf_raddr];
    end

    int cyc = 0;
    always @(posedge clk2) cyc <= cyc + 1;

    // Ready: constant 1, or an LFSR bit (about 50%) updated just after each edge.
    int          ready_mode = 0;
    logic        ready_rand = 1'b1;
    logic [15:0] lfsr = 16'hACE1;
    always @(posedge clk2) begin
        #1;
        lfsr       = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        ready_rand = lfsr[0];
    end
    assign m_ready = (ready_mode != 0) ? ready_rand : 1'b1;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Monitor logs
    logic [16:0] w_word[$];   // {m_last, m_data} per handshake
    int          ra_log[$];
    int          done_log[$];
    int          first_valid;
    int          last_valid;
    int          valid_cnt;
    bit          busy_seen;
    bit          occ_watch = 1'b0;
    bit          prev_stall;
    logic [16:0] prev_word;

    task automatic clear_log();
        w_word.delete();
        ra_log.delete();
        done_log.delete();
        first_valid = -1;
        last_valid  = -1;
        valid_cnt   = 0;
        busy_seen   = 1'b0;
        prev_stall  = 1'b0;
    endtask

    always @(negedge clk2) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {14'd0, m_valid, m_last, m_data}, {14'd0, 1'b1, prev_word});
            prev_stall = m_valid && !m_ready;
            prev_word  = {m_last, m_data};
            if (m_valid) begin
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                valid_cnt++;
            end
            if (m_valid && m_ready) w_word.push_back({m_last, m_data});
            if (rf_ren) ra_log.push_back(int'(rf_raddr));
            if (done) done_log.push_back(cyc);
            if (busy) busy_seen = 1'b1;
            if (occ_watch) check("occ_le_buf_depth", {31'd0, dut.occ_q <= 3'(BUF_DEPTH)}, 32'd1);
        end
    end

    function automatic int addr_at(input int b, input int k, input bit d);
        return d ? (b - k + DEPTH) % DEPTH : (b + k) % DEPTH;
    endfunction

    // Returns the edge index at which start was sampled.
    task automatic do_start(input int b, input int n, input bit d, output int se);
        @(posedge clk2); #1;
        base_addr = ADDR_W'(b);
        count     = CNT_W'(n);
        dir       = d;
        start     = 1'b1;
        @(posedge clk2); #1;
        start = 1'b0;
        se    = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done_log.size() == 0 && i < budget) begin
            @(negedge clk2);
            i++;
        end
        repeat (3) @(negedge clk2);
        check(tag, done_log.size(), 32'd1);
    endtask

    task automatic check_words(input string tag, input int b, input int n, input bit d);
        check({tag, "_count"}, w_word.size(), n);
        for (int k = 0; k < n && k < w_word.size(); k++) begin
            int a;
            a = addr_at(b, k, d);
            check({tag, "_word"}, {15'd0, w_word[k]}, {15'd0, 1'(k == n - 1), 16'(a * 3)});
        end
    endtask

    task automatic check_raddr(input string tag, input int b, input int n, input bit d);
        check({tag, "_nreads"}, ra_log.size(), n);
        for (int k = 0; k < n && k < ra_log.size(); k++)
            check({tag, "_raddr"}, ra_log[k], addr_at(b, k, d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int se;
        int i;

        for (int a = 0; a < DEPTH; a++) rf_mem[a] = 16'(a * 3);
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; dir = 1'b0;
        clear_log();

        // Reset state
        repeat (3) @(posedge clk2);
        #1 rst = 1'b0;
        @(negedge clk2);
        check("rst_ctrl", {27'd0, busy, done, rf_ren, m_valid, m_last}, 32'd0);
        check("rst_data", {10'd0, rf_raddr, m_data}, 32'd0);

        // Ascending burst with latency and single done pulse
        clear_log();
        do_start(5, 8, 1'b0, se);
        wait_done("asc_done", 40);
        check_words("asc", 5, 8, 1'b0);
        check_raddr("asc", 5, 8, 1'b0);
        check("asc_first_valid", first_valid, se + 2);
        check("asc_valid_cnt", valid_cnt, 8);
        check("asc_span", last_valid - first_valid, 7);
        if (done_log.size() > 0) check("asc_done_cyc", done_log[0], se + 11);

        // Ascending wrap 62,63,0,1
        clear_log();
        do_start(62, 4, 1'b0, se);
        wait_done("wrap_up_done", 40);
        check_raddr("wrap_up", 62, 4, 1'b0);
        check_words("wrap_up", 62, 4, 1'b0);

        // Descending wrap 1,0,63,62
        clear_log();
        do_start(1, 4, 1'b1, se);
        wait_done("wrap_dn_done", 40);
        check_raddr("wrap_dn", 1, 4, 1'b1);
        check_words("wrap_dn", 1, 4, 1'b1);

        // Backpressure, 64 words with random ready
        clear_log();
        ready_mode = 1;
        occ_watch  = 1'b1;
        do_start(0, 64, 1'b0, se);
        wait_done("bp_done", 600);
        occ_watch  = 1'b0;
        ready_mode = 0;
        check_words("bp", 0, 64, 1'b0);
        check("bp_stalled", {31'd0, valid_cnt > 64}, 32'd1);

        // Zero count: no reads, no data, done on the next cycle
        clear_log();
        do_start(20, 0, 1'b0, se);
        wait_done("zero_done", 10);
        if (done_log.size() > 0) check("zero_done_cyc", done_log[0], se);
        check("zero_reads", ra_log.size(), 0);
        check("zero_valid", valid_cnt, 0);
        check("zero_busy", {31'd0, busy_seen}, 32'd0);

        // Oversized count clips to DEPTH
        clear_log();
        do_start(10, 100, 1'b1, se);
        wait_done("clip_done", 200);
        check_words("clip", 10, 64, 1'b1);

        // Start pulsed mid-burst is ignored
        clear_log();
        do_start(5, 8, 1'b0, se);
        repeat (2) @(posedge clk2);
        #1;
        base_addr = 6'd40; count = 7'd3; start = 1'b1;
        @(posedge clk2); #1 start = 1'b0;
        wait_done("ign_done", 40);
        repeat (5) @(negedge clk2);
        check_words("ign", 5, 8, 1'b0);
        check_raddr("ign", 5, 8, 1'b0);
        check("ign_one_done", done_log.size(), 1);

        // Reset after the third word
        clear_log();
        do_start(0, 10, 1'b0, se);
        i = 0;
        while (w_word.size() < 3 && i < 40) begin
            @(negedge clk2);
            i++;
        end
        check("rst_mid_reached", {31'd0, w_word.size() >= 3}, 32'd1);
        @(posedge clk2); #1 rst = 1'b1;
        @(posedge clk2); #1 rst = 1'b0;
        @(negedge clk2);
        check("rst_mid_ctrl", {27'd0, busy, done, rf_ren, m_valid, m_last}, 32'd0);
        check("rst_mid_data", {10'd0, rf_raddr, m_data}, 32'd0);
        repeat (10) @(negedge clk2);
        check("rst_mid_no_done", done_log.size(), 0);
        clear_log();
        do_start(0, 2, 1'b0, se);
        wait_done("post_rst_done", 40);
        check_words("post_rst", 0, 2, 1'b0);

        // Full throughput: 64 back-to-back words, done 65 cycles after first valid
        clear_log();
        do_start(0, 64, 1'b0, se);
        wait_done("full_done", 200);
        check("full_first_valid", first_valid, se + 2);
        check("full_valid_cnt", valid_cnt, 64);
        check("full_span", last_valid - first_valid, 63);
        if (done_log.size() > 0) check("full_done_cyc", done_log[0], se + 67);
        check_words("full", 0, 64, 1'b0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_regfile_reader.md
Name: fir_regfile_reader

Overview:
- Read-side sequencer for the FIR coefficient/sample register file.
- On a start command it issues a burst of reads to the register file's registered read port.
- It absorbs the regfile's 1-cycle read latency and presents the returned words as a valid/ready stream to the FIR MAC datapath.
- Supports ascending or descending circular addressing, so the sample history can be walked newest-to-oldest.

Parameters:
- DEPTH, 64: number of regfile entries; the address wrap point.
- WIDTH, 16: data word width (signed).
- ADDR_W, 6: regfile address width.
- CNT_W, 7: burst length field width; must hold DEPTH.
- BUF_DEPTH, 4: output buffer entries; must be at least 4 for full throughput.

Ports:
- clk2  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  burst request; single-cycle pulse, sampled only in IDLE.
- base_addr  in  ADDR_W  first address of the burst.
- count  in  CNT_W  number of words to read; 0 is legal.
- dir  in  1  0 = ascending addresses, 1 = descending addresses.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at burst completion.
- rf_ren  out  1  regfile read enable; registered.
- rf_raddr  out  ADDR_W  regfile read address; registered.
- rf_dout  in  WIDTH  regfile read data; valid 1 cycle after rf_ren/rf_raddr.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  WIDTH  output word.
- m_last  out  1  marks the final word of the burst.

Behaviour:
- Reset (rst sampled high):
  - State goes to IDLE.
  - busy, done, rf_ren, m_valid and m_last go to 0; rf_raddr and m_data go to 0.
  - Buffer emptied and outstanding counter cleared.
  - All of this takes effect from the cycle after the edge.
  - Reset mid-burst discards all in-flight and buffered data; no done pulse is produced.
- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches base_addr, dir and the effective count. Effective count is min(count, DEPTH).
    - Effective count = 0: stay in IDLE, no reads, done=1 in the next cycle, busy stays 0.
    - Otherwise: go to RUN.
  - RUN: issue reads. After the read for the final word is issued, go to DRAIN.
  - DRAIN: no new reads. When the last word completes its handshake, go to IDLE and pulse done in the following cycle.
  - start while not IDLE is ignored.
- Read issue:
  - A read is issued in a cycle only when remaining > 0 and buf_occupancy + outstanding < BUF_DEPTH.
  - outstanding = reads issued but not yet written into the buffer (0..2).
  - Issuing drives rf_ren=1 and rf_raddr=current address in the next cycle; rf_ren is 0 in all non-issue cycles.
- Address sequence:
  - Ascending: DEPTH-1 wraps to 0.
  - Descending: 0 wraps to DEPTH-1.
  - Wrap uses an explicit compare against DEPTH-1 / 0, so a non-power-of-2 DEPTH is handled.
- Return path: rf_dout is captured into the buffer on the edge following the cycle in which it is valid. Capture order equals issue order.
- Output interface:
  - m_valid, m_data and m_last come from the buffer head, registered.
  - A handshake occurs on m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
  - m_last=1 only on the final word of the burst.
- Latency and throughput:
  - start sampled at edge E0 → rf_ren high after E0 → rf_dout valid after E1 → captured at E2 → m_valid high after E2.
  - With m_ready held at 1: one word per cycle, no bubbles.
- Buffer must never overflow; this is guaranteed by the issue rule. Assertion in bench: occupancy never exceeds BUF_DEPTH.
- Data is passed through unmodified (signed WIDTH bits). No arithmetic on data.
- Counters: remaining is CNT_W bits; address is ADDR_W bits.

Test Plan:
- Ascending burst: preload mem[i]=i*3; start base=5 count=8 dir=0, m_ready=1 → m_data 15,18,...,36 on consecutive cycles. m_last on 36; first m_valid 2 cycles after start edge; one done pulse.
- Wrap in both directions:
  - base=62 count=4 dir=0 → rf_raddr 62,63,0,1; data 186,189,0,3.
  - base=1 count=4 dir=1 → rf_raddr 1,0,63,62.
- Backpressure: count=64, m_ready pseudo-random at 50% → all 64 words in order, none dropped or duplicated. m_data stable during stalls; occupancy ≤ 4.
- Degenerate counts:
  - count=0 → no rf_ren, no m_valid, done exactly 1 cycle after start.
  - count=100 → exactly 64 words, m_last on the 64th.
- Control hazards:
  - start pulsed during a burst → ignored; word count unchanged.
  - rst asserted after the 3rd word → all outputs 0 the next cycle, no done. A new burst base=0 count=2 then returns 0,3 correctly.
- Full throughput check: m_ready=1, count=64 → exactly 64 consecutive m_valid cycles, and done 65 cycles after the first m_valid.
